// File: rtl/lector_temperatura.sv
// lector_temperatura
//   Periodically reads an N-bit unsigned temperature sample from an SPI-style
//   sensor (mode 0, MSB first) and derives fan/alarm request flags with
//   hysteresis. Each completed reading is announced by a one-cycle pulse on
//   lectura. Every output comes straight from a flop.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active low
//   en            enables periodic readings
//   miso          sensor serial data
//   sclk          sensor serial clock (clk / (2*DIV))
//   cs_n          sensor chip select, active low
//   temp          last completed sample
//   ac_ventilador fan request flag
//   ac_alarma     alarm request flag
//   lectura       one-cycle pulse: temp and flags just updated
//   ocupado       high while a reading is in progress
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | cs_n high; gap counter runs down; start when en and gap=0
// CS_SETUP | cs_n low for DIV cycles before the first sclk period
// SHIFT    | N sclk periods (DIV low, DIV high); capture on rising sclk
// DONE     | one cycle: lectura high, temp and flags just loaded
module lector_temperatura #(
    parameter int N             = 8,
    parameter int DIV           = 2,
    parameter int GAP           = 16,
    parameter int UMBRAL_VENT   = 30,
    parameter int UMBRAL_ALARMA = 45,
    parameter int HIST          = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         miso,
    output logic         sclk,
    output logic         cs_n,
    output logic [N-1:0] temp,
    output logic         ac_ventilador,
    output logic         ac_alarma,
    output logic         lectura,
    output logic         ocupado
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] CNT_LOAD  = CW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
    localparam logic [N-1:0]  SET_VENT  = N'(UMBRAL_VENT);
    localparam logic [N-1:0]  CLR_VENT  = N'(UMBRAL_VENT - HIST);
    localparam logic [N-1:0]  SET_ALARM = N'(UMBRAL_ALARMA);
    localparam logic [N-1:0]  CLR_ALARM = N'(UMBRAL_ALARMA - HIST);

    typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [N-1:0]  temp_q, temp_d;
    logic          sclk_q, sclk_d;
    logic          cs_n_q, cs_n_d;
    logic          vent_q, vent_d;
    logic          alarm_q, alarm_d;
    logic          lectura_q, lectura_d;
    logic          ocupado_q, ocupado_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            temp_q    <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            vent_q    <= 1'b0;
            alarm_q   <= 1'b0;
            lectura_q <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            temp_q    <= temp_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            vent_q    <= vent_d;
            alarm_q   <= alarm_d;
            lectura_q <= lectura_d;
            ocupado_q <= ocupado_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        temp_d    = temp_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        vent_d    = vent_q;
        alarm_d   = alarm_q;
        lectura_d = 1'b0;
        ocupado_d = ocupado_q;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else if (en) begin
                    state_d   = CS_SETUP;
                    cs_n_d    = 1'b0;
                    ocupado_d = 1'b1;
                    cnt_d     = CNT_LOAD;
                end
            end
            CS_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                    cnt_d   = CNT_LOAD;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!sclk_q) begin
                    // This edge raises sclk; the sensor's bit has been stable
                    // since the previous falling edge.
                    sclk_d = 1'b1;
                    sh_d   = {sh_q[N-2:0], miso};
                    cnt_d  = CNT_LOAD;
                end else if (bit_q == BIT_LAST) begin
                    state_d   = DONE;
                    sclk_d    = 1'b0;
                    cs_n_d    = 1'b1;
                    lectura_d = 1'b1;
                    temp_d    = sh_q;
                    if (sh_q >= SET_VENT) vent_d = 1'b1;
                    else if (sh_q < CLR_VENT) vent_d = 1'b0;
                    if (sh_q >= SET_ALARM) alarm_d = 1'b1;
                    else if (sh_q < CLR_ALARM) alarm_d = 1'b0;
                end else begin
                    sclk_d = 1'b0;
                    bit_d  = bit_q + BW'(1);
                    cnt_d  = CNT_LOAD;
                end
            end
            DONE: begin
                state_d   = IDLE;
                gap_d     = GAP_LOAD;
                ocupado_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sclk          = sclk_q;
    assign cs_n          = cs_n_q;
    assign temp          = temp_q;
    assign ac_ventilador = vent_q;
    assign ac_alarma     = alarm_q;
    assign lectura       = lectura_q;
    assign ocupado       = ocupado_q;

endmodule

// File: tb/tb_lector_temperatura.sv
module tb_lector_temperatura;

    localparam int N      = 8;
    localparam int DIV    = 2;
    localparam int GAP    = 16;
    localparam int UV     = 30;
    localparam int UA     = 45;
    localparam int HIST   = 2;
    localparam int LAT    = DIV * (2 * N + 1);
    localparam int PERIOD = DIV * (2 * N + 1) + GAP + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         miso;
    logic         sclk;
    logic         cs_n;
    logic [N-1:0] temp;
    logic         ac_ventilador;
    logic         ac_alarma;
    logic         lectura;
    logic         ocupado;

    lector_temperatura #(
        .N(N), .DIV(DIV), .GAP(GAP),
        .UMBRAL_VENT(UV), .UMBRAL_ALARMA(UA), .HIST(HIST)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .miso(miso),
        .sclk(sclk), .cs_n(cs_n), .temp(temp),
        .ac_ventilador(ac_ventilador), .ac_alarma(ac_alarma),
        .lectura(lectura), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: flags evolve reading by reading from the sample values.
    typedef struct {int t; int v; int a;} exp_t;
    exp_t exp_q[$];
    int   sens_q[$];
    int   mv = 0;
    int   ma = 0;

    function automatic void model_push(input int w);
        if (w >= UV) mv = 1;
        else if (w < UV - HIST) mv = 0;
        if (w >= UA) ma = 1;
        else if (w < UA - HIST) ma = 0;
        exp_q.push_back('{w, mv, ma});
    endfunction

    // Sensor model: presents MSB when selected, next bit after each sclk fall.
    initial begin : sensor
        logic [N-1:0] word;
        int           idx;
        logic         pcs, psclk;
        miso = 1'b0; pcs = 1'b1; psclk = 1'b0; idx = 0; word = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pcs = 1'b1; psclk = 1'b0; miso = 1'b0;
            end else begin
                if (pcs && !cs_n) begin
                    if (sens_q.size() > 0) word = N'(sens_q.pop_front());
                    else word = N'($urandom);
                    model_push(int'(word));
                    idx  = N - 1;
                    miso = word[idx];
                end else if (!cs_n && psclk && !sclk && idx > 0) begin
                    idx--;
                    miso = word[idx];
                end
                pcs = cs_n; psclk = sclk;
            end
        end
    end

    int lect_cnt = 0;
    int cs_falls = 0;
    int sclk_bad = 0;

    // Monitor: pops the scoreboard on every lectura pulse.
    initial begin : monitor
        logic pcs, psclk, plect;
        int   cs_cyc, rises, last_lect;
        bit   last_ok, en_low;
        exp_t e;
        pcs = 1'b1; psclk = 1'b0; plect = 1'b0;
        cs_cyc = 0; rises = 0; last_lect = 0; last_ok = 0; en_low = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pcs = 1'b1; psclk = 1'b0; plect = 1'b0; last_ok = 0;
            end else begin
                if (!en) en_low = 1;
                if (cs_n && sclk) sclk_bad++;
                if (pcs && !cs_n) begin
                    cs_cyc = cyc; rises = 0; cs_falls++;
                end
                if (!cs_n && !psclk && sclk) rises++;
                if (plect) begin
                    check("lectura_width", int'(lectura), 0);
                    check("ocupado_after_done", int'(ocupado), 0);
                end
                if (lectura) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL lectura_unexpected: got pulse expected none (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("temp", int'(temp), e.t);
                        check("ac_ventilador", int'(ac_ventilador), e.v);
                        check("ac_alarma", int'(ac_alarma), e.a);
                    end
                    check("lectura_latency", cyc - cs_cyc, LAT);
                    check("sclk_rises", rises, N);
                    if (last_ok && !en_low) check("lectura_period", cyc - last_lect, PERIOD);
                    last_lect = cyc; last_ok = 1; en_low = 0;
                    lect_cnt++;
                end
                pcs = cs_n; psclk = sclk; plect = lectura;
            end
        end
    end

    task automatic wait_lect(input int n, input int budget);
        int start, k;
        start = lect_cnt; k = 0;
        while (lect_cnt < start + n && k < budget) begin
            @(negedge clk); k++;
        end
        if (lect_cnt < start + n) begin
            n_checks++; n_fail++;
            $display("FAIL lectura_timeout: got %0d pulses expected %0d", lect_cnt - start, n);
        end
    endtask

    task automatic wait_cs_low(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (cs_n && k < budget);
        if (cs_n) begin
            n_checks++; n_fail++;
            $display("FAIL cs_start_timeout: got cs_n=1 expected 0");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, int'(cs_n), 1);
        check({tag, "_sclk"}, int'(sclk), 0);
        check({tag, "_temp"}, int'(temp), 0);
        check({tag, "_vent"}, int'(ac_ventilador), 0);
        check({tag, "_alarma"}, int'(ac_alarma), 0);
        check({tag, "_lectura"}, int'(lectura), 0);
        check({tag, "_ocupado"}, int'(ocupado), 0);
    endtask

    initial begin : main
        int f;
        rst = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_init");
        #1 rst = 1'b1;

        // Single reading of 31.
        sens_q.push_back(31);
        @(negedge clk); en = 1'b1;
        wait_lect(1, 100);
        en = 1'b0;
        check("single_temp", int'(temp), 31);
        check("single_vent", int'(ac_ventilador), 1);
        check("single_alarma", int'(ac_alarma), 0);
        repeat (30) @(negedge clk);

        // Hysteresis sequence with en held high.
        foreach (sens_q[i]) sens_q.delete(i);
        sens_q.push_back(31); sens_q.push_back(29); sens_q.push_back(27);
        sens_q.push_back(46); sens_q.push_back(44); sens_q.push_back(42);
        en = 1'b1;
        wait_lect(6, 420);
        en = 1'b0;
        repeat (30) @(negedge clk);

        // Random readings, continuous enable.
        en = 1'b1;
        wait_lect(10, 700);
        en = 1'b0;
        repeat (30) @(negedge clk);

        // en dropped 10 cycles after start.
        sens_q.push_back(50);
        en = 1'b1;
        wait_cs_low(60);
        repeat (10) @(negedge clk);
        en = 1'b0;
        wait_lect(1, 100);
        f = cs_falls;
        repeat (80) @(negedge clk);
        check("no_start_while_en_low", cs_falls, f);
        check("temp_before_reset", int'(temp), 50);

        // Reset in the middle of SHIFT.
        en = 1'b1;
        wait_cs_low(60);
        repeat (11) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        exp_q.delete(); mv = 0; ma = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_held");
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("start_after_release_cs_n", int'(cs_n), 0);
        check("start_after_release_ocupado", int'(ocupado), 1);
        wait_lect(1, 100);
        en = 1'b0;
        repeat (30) @(negedge clk);

        check("sclk_toggle_cs_high", sclk_bad, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lector_temperatura.md
# lector_temperatura

Serial temperature-sensor reader that produces the `ac_ventilador`, `ac_alarma` and `lectura` inputs consumed by the fan/alarm `fsm`. While enabled, it clocks an N-bit unsigned temperature sample out of an SPI-style sensor (mode 0, MSB first). It compares the sample against fan and alarm thresholds with hysteresis, and announces each new reading with a one-cycle `lectura` pulse. It sits between the sensor pins and the `fsm` control inputs.

## Interface
- `N`, 8: sample width in bits.
- `DIV`, 2: clk cycles per half-period of `sclk` and length of the CS setup phase (≥1).
- `GAP`, 16: idle clk cycles between the end of one reading and the next start.
- `UMBRAL_VENT`, 30: fan set threshold (unsigned, N bits).
- `UMBRAL_ALARMA`, 45: alarm set threshold (unsigned, N bits).
- `HIST`, 2: hysteresis. Constraint: `HIST` ≤ both thresholds.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  enables periodic readings.
- `miso`  in  1  sensor serial data.
- `sclk`  out  1  sensor serial clock.
- `cs_n`  out  1  sensor chip select, active-low.
- `temp`  out  N  last completed sample.
- `ac_ventilador`  out  1  fan request flag, with hysteresis.
- `ac_alarma`  out  1  alarm request flag, with hysteresis.
- `lectura`  out  1  one-cycle pulse: new `temp` and flags valid.
- `ocupado`  out  1  high while a reading is in progress.

## Operation
- All outputs are registered.
- Reset values: `cs_n`=1; `sclk`=0; `temp`=0; `ac_ventilador`=0; `ac_alarma`=0; `lectura`=0; `ocupado`=0.
- Reset values of internal state: state=IDLE; gap counter=0.
- FSM states: IDLE → CS_SETUP → SHIFT → DONE → IDLE.
- IDLE:
  - `cs_n`=1, `sclk`=0.
  - The gap counter decrements to 0.
  - When `en`=1 and the gap counter is 0, the FSM moves to CS_SETUP.
- CS_SETUP:
  - `cs_n`=0, `ocupado`=1, `sclk`=0, lasting DIV cycles; then the FSM moves to SHIFT.
- SHIFT:
  - N bit periods, each DIV cycles with `sclk`=0 followed by DIV cycles with `sclk`=1.
  - `miso` is sampled into the shift register on the clk edge that drives `sclk` from 0 to 1, MSB first.
  - The sensor changes `miso` after `sclk` falls.
  - After the N-th high half-period, the FSM moves to DONE.
- DONE (1 cycle):
  - `cs_n`=1, `sclk`=0, `lectura`=1.
  - `temp` is loaded with the shift register.
  - Flags are updated from the new sample.
  - The gap counter is loaded with GAP.
  - The FSM returns to IDLE, and `ocupado` drops.
- Flag update rule (unsigned compare, X = VENT or ALARMA):
  - `temp` ≥ UMBRAL_X sets the flag.
  - `temp` < UMBRAL_X−HIST clears the flag.
  - Otherwise the flag holds.
- Flags and `temp` change only in DONE or on reset.
- `en` dropped mid-reading: the current reading completes normally, including the `lectura` pulse. The FSM then stays in IDLE.
- `en` raised while the gap counter is nonzero: the start waits until the counter reaches 0.
- `rst` asserted at any time: all outputs and state return to their reset values immediately. A partial sample is discarded, with no `lectura` pulse. The first reading after release starts on the first edge with `en`=1.

## Timing
- Start edge t: the edge at which IDLE sees `en`=1 and gap=0.
- Cycle t+1: `cs_n` low.
- Sample capture edges: t+1+DIV+DIV·(2k+1), for k = 0..N−1.
- `lectura` high in cycle t+1+DIV·(2N+1). Defaults: t+35.
- Period between consecutive `lectura` pulses with `en` held high: DIV·(2N+1)+GAP+2. Defaults: 52 cycles.
- `sclk` frequency is clk/(2·DIV). `sclk` never toggles while `cs_n`=1.

## Test plan
- Reset: drive `rst`=0 mid-simulation → all outputs at their reset values. `cs_n`=1 and `sclk`=0 with no clock edge required.
- Single reading: defaults, sensor model shifts 0x1F (31) → `lectura` at t+35, `temp`=0x1F, `ac_ventilador`=1, `ac_alarma`=0. Exactly 8 `sclk` rising edges occur while `cs_n`=0.
- Hysteresis sequence: readings 31, 29, 27, 46, 44, 42 → `ac_ventilador` 1,1,0,1,1,1. `ac_alarma` 0,0,0,1,1,0.
- `en` dropped 10 cycles after start → reading completes with `lectura` at t+35. No further `cs_n` low while `en`=0.
- Reset mid-SHIFT (cycle t+12): `temp` and flags keep their reset values, and `cs_n` returns to 1. With `en` held high, a new start occurs on the first edge after release.
- Continuous `en`=1 → `lectura` pulses spaced exactly 52 cycles apart, each exactly 1 cycle wide.
